pc_sequencer: RTL

- Next-PC controller sitting in front of the fetch-stage PC register.
- Each cycle it selects among four sources: sequential (PC+4), branch target, jump target, and exception vector.
- It honours stall from the hazard unit and the instruction-memory ready handshake.
- It buffers redirects that arrive while fetch is frozen, and issues flush pulses to the IF/ID stage.

---
 rtl/pc_seq_pkg.sv | 25 ++
 rtl/pc_redirect_sel.sv | 52 +++++
 rtl/pc_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and default vectors for the fetch-stage PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    WAIT,
    PEND
  } pc_state_e;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_BR,
    SRC_JMP,
    SRC_EXC
  } redirect_src_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

  function automatic logic is_misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Priority mux over redirect requests (exception > jump > branch) with a
// word-alignment check that turns a bad branch/jump target into an exception.
module pc_redirect_sel
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              exception,
  output logic              valid,
  output redirect_src_e     src,
  output logic [ADDR_W-1:0] target,
  output logic              misaligned
);

  always_comb begin
    valid      = 1'b0;
    src        = SRC_NONE;
    target     = '0;
    misaligned = 1'b0;
    if (exception) begin
      valid  = 1'b1;
      src    = SRC_EXC;
      target = EXC_VECTOR;
    end else if (jump) begin
      valid = 1'b1;
      if (is_misaligned(jump_target[1:0])) begin
        src        = SRC_EXC;
        target     = EXC_VECTOR;
        misaligned = 1'b1;
      end else begin
        src    = SRC_JMP;
        target = jump_target;
      end
    end else if (branch_taken) begin
      valid = 1'b1;
      if (is_misaligned(branch_target[1:0])) begin
        src        = SRC_EXC;
        target     = EXC_VECTOR;
        misaligned = 1'b1;
      end else begin
        src    = SRC_BR;
        target = branch_target;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller in front of the fetch PC register: sequential, branch, jump and
// exception sources, stall/ready handling, redirect buffering. PC_SEQ_PERF_EN adds counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              imem_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              exception,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_valid,
  output logic              flush,
  output logic              misaligned
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       redirect_cnt_o
`endif
);

  pc_state_e         state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              fv_q;
  logic [ADDR_W-1:0] pend_target_q;
  redirect_src_e     pend_src_q;

  logic              sel_valid;
  redirect_src_e     sel_src;
  logic [ADDR_W-1:0] sel_target;
  logic              sel_misaligned;

  logic adv;
  logic req;
  logic take_now;
  logic buffer_req;
  logic release_pend;
  logic keep_pend;

  pc_redirect_sel #(
    .ADDR_W     (ADDR_W),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_redirect_sel (
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .exception     (exception),
    .valid         (sel_valid),
    .src           (sel_src),
    .target        (sel_target),
    .misaligned    (sel_misaligned)
  );

  assign adv = fv_q & imem_ready & ~stall;

  // Requests arriving while still in BOOT are dropped entirely.
  assign req          = (state_q != BOOT) & sel_valid;
  assign take_now     = req & ((sel_src == SRC_EXC) | ~stall);
  assign buffer_req   = req & ~take_now;
  assign release_pend = (state_q == PEND) & ~req & ~stall;
  assign keep_pend    = (state_q == PEND) & (pend_src_q == SRC_EXC);

  assign pc_out      = pc_q;
  assign pc_plus4    = pc_q + ADDR_W'(4);
  assign fetch_valid = fv_q;
  assign flush       = req;
  assign misaligned  = req & sel_misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      fv_q          <= 1'b0;
      pend_target_q <= '0;
      pend_src_q    <= SRC_NONE;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_q <= RUN;
          fv_q    <= 1'b1;
        end
        RUN, WAIT, PEND: begin
          if (take_now) begin
            pc_q          <= sel_target;
            state_q       <= RUN;
            fv_q          <= 1'b1;
            pend_target_q <= '0;
            pend_src_q    <= SRC_NONE;
          end else if (buffer_req) begin
            if (!keep_pend) begin
              pend_target_q <= sel_target;
              pend_src_q    <= sel_src;
            end
            state_q <= PEND;
            fv_q    <= 1'b0;
          end else if (state_q == PEND) begin
            if (release_pend) begin
              pc_q          <= pend_target_q;
              state_q       <= RUN;
              fv_q          <= 1'b1;
              pend_target_q <= '0;
              pend_src_q    <= SRC_NONE;
            end
          end else if (adv) begin
            pc_q    <= pc_plus4;
            state_q <= RUN;
          end else begin
            state_q <= WAIT;
          end
        end
        default: begin
          state_q <= BOOT;
          fv_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] redirect_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (adv && (fetch_cnt_q != '1)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if ((take_now || release_pend) && (redirect_cnt_q != '1)) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt_o    = fetch_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule
